tpu_mmio_ctrl: RTL and testbench

Second-generation MMIO register file and run sequencer for the systolic matrix accelerator. It decodes CPU loads and stores into ID, control, status, interrupt, repeat and performance registers. It decodes packed A/B operand buffer writes with byte-strobe lane masking and sequences one or more back-to-back matrix runs, driving capture/clear pulses to the array. It sits between the SoC MMIO port and the A/B buffers, systolic array and result capture logic, and adds an interrupt line to the SoC.

---
 rtl/tpu_mmio_ctrl.sv | 221 ++++++++++++++++++++++
 tb/tb_tpu_mmio_ctrl.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_mmio_ctrl.sv
// MMIO register file, packed A/B buffer write decode and repeat-run sequencer for the systolic array.
// Reads and buffer write enables are combinational; control takes effect on the next edge; the port never stalls.
module tpu_mmio_ctrl #(
   parameter int          N             = 4,
   parameter int          DATA_W        = 8,
   parameter int          SUM_W         = 32,
   parameter int          REP_W         = 8,
   parameter logic [15:0] TPU_BASE      = 16'h0000,
   parameter logic [31:0] ID_VALUE      = 32'h5450_0002,
   parameter logic [31:0] VERSION_VALUE = 32'h0002_0000,
   localparam int PACK       = 32 / DATA_W,
   localparam int WORDS      = (N*N + PACK - 1) / PACK,
   localparam int RUN_CYCLES = 3*N,
   localparam int TW         = $clog2(RUN_CYCLES + 1),
   localparam int WA_W       = (WORDS > 1) ? $clog2(WORDS) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     mmio_wr,
   input  logic                     mmio_rd,
   input  logic [15:0]              mmio_addr,
   input  logic [31:0]              mmio_wdata,
   input  logic [3:0]               mmio_wstrb,
   input  logic [DATA_W*N*N-1:0]    a_flat,
   input  logic [DATA_W*N*N-1:0]    b_flat,
   input  logic [SUM_W*N*N-1:0]     c_flat,
   output logic [31:0]              mmio_rdata,
   output logic                     mmio_ready,
   output logic                     busy,
   output logic                     done,
   output logic                     irq,
   output logic                     capture_sums,
   output logic                     clear_acc,
   output logic [TW-1:0]            t_ctr,
   output logic [1:0]               state,
   output logic [PACK-1:0]          we_a,
   output logic [PACK-1:0]          we_b,
   output logic [WA_W-1:0]          addr_a,
   output logic [WA_W-1:0]          addr_b,
   output logic [31:0]              wdata_a,
   output logic [31:0]              wdata_b
);

   typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2} state_t;

   localparam int            BPL    = DATA_W / 8;
   localparam int            NN     = N * N;
   localparam logic [TW-1:0] T_LAST = TW'(RUN_CYCLES - 1);

   state_t            st;
   logic              err;
   logic [1:0]        irq_en;
   logic [1:0]        irq_stat;
   logic [REP_W-1:0]  rep_cnt;
   logic [REP_W-1:0]  rep_left;
   logic [31:0]       cycles;

   logic [15:0]       off;
   logic [13:0]       word, a_rel, b_rel, c_rel;
   logic              aligned, reg_hit, a_hit, b_hit, c_hit;
   logic              wr_ctrl, wr_irq_en, wr_irq_stat, wr_rep;
   logic              start, clr_done, abort, ab_busy_err;
   logic [PACK-1:0]   lanes_a, lanes_b;

   // Relative word indices wrap to large values below each window, so one compare bounds both ends.
   assign off     = mmio_addr - TPU_BASE;
   assign aligned = (off[1:0] == 2'b00);
   assign word    = off[15:2];
   assign a_rel   = word - 14'h040;
   assign b_rel   = word - 14'h080;
   assign c_rel   = word - 14'h0C0;
   assign reg_hit = aligned && (word < 14'd8);
   assign a_hit   = aligned && (a_rel < 14'(WORDS));
   assign b_hit   = aligned && (b_rel < 14'(WORDS));
   assign c_hit   = aligned && (c_rel < 14'(NN));

   assign wr_ctrl     = mmio_wr && reg_hit && (word[2:0] == 3'd2) && mmio_wstrb[0];
   assign wr_irq_en   = mmio_wr && reg_hit && (word[2:0] == 3'd4) && mmio_wstrb[0];
   assign wr_irq_stat = mmio_wr && reg_hit && (word[2:0] == 3'd5) && mmio_wstrb[0];
   assign wr_rep      = mmio_wr && reg_hit && (word[2:0] == 3'd6);
   assign start       = wr_ctrl && mmio_wdata[0];
   assign clr_done    = wr_ctrl && mmio_wdata[1];
   assign abort       = wr_ctrl && mmio_wdata[2];
   assign ab_busy_err = mmio_wr && busy && (a_hit || b_hit);

   always_comb begin
      lanes_a = '0;
      lanes_b = '0;
      for (int l = 0; l < PACK; l++) begin
         lanes_a[l] = (&mmio_wstrb[l*BPL +: BPL]) && ((int'(a_rel) * PACK + l) < NN);
         lanes_b[l] = (&mmio_wstrb[l*BPL +: BPL]) && ((int'(b_rel) * PACK + l) < NN);
      end
   end

   assign we_a    = (mmio_wr && a_hit && !busy) ? lanes_a : '0;
   assign we_b    = (mmio_wr && b_hit && !busy) ? lanes_b : '0;
   assign addr_a  = (mmio_wr && a_hit) ? a_rel[WA_W-1:0] : '0;
   assign addr_b  = (mmio_wr && b_hit) ? b_rel[WA_W-1:0] : '0;
   assign wdata_a = (mmio_wr && a_hit) ? mmio_wdata : '0;
   assign wdata_b = (mmio_wr && b_hit) ? mmio_wdata : '0;

   assign mmio_ready = 1'b1;
   assign state      = st;

   always_comb begin
      mmio_rdata = '0;
      if (mmio_rd) begin
         if (reg_hit) begin
            case (word[2:0])
               3'd0:    mmio_rdata = ID_VALUE;
               3'd1:    mmio_rdata = VERSION_VALUE;
               3'd3:    mmio_rdata = {29'b0, err, done, busy};
               3'd4:    mmio_rdata = {30'b0, irq_en};
               3'd5:    mmio_rdata = {30'b0, irq_stat};
               3'd6:    mmio_rdata[REP_W-1:0] = rep_cnt;
               3'd7:    mmio_rdata = cycles;
               default: mmio_rdata = '0;
            endcase
         end else if (a_hit) begin
            for (int l = 0; l < PACK; l++)
               if ((int'(a_rel) * PACK + l) < NN)
                  mmio_rdata[l*DATA_W +: DATA_W] = a_flat[(int'(a_rel) * PACK + l) * DATA_W +: DATA_W];
         end else if (b_hit) begin
            for (int l = 0; l < PACK; l++)
               if ((int'(b_rel) * PACK + l) < NN)
                  mmio_rdata[l*DATA_W +: DATA_W] = b_flat[(int'(b_rel) * PACK + l) * DATA_W +: DATA_W];
         end else if (c_hit) begin
            mmio_rdata[SUM_W-1:0] = c_flat[int'(c_rel) * SUM_W +: SUM_W];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st           <= S_IDLE;
         busy         <= 1'b0;
         done         <= 1'b0;
         err          <= 1'b0;
         irq          <= 1'b0;
         capture_sums <= 1'b0;
         clear_acc    <= 1'b0;
         t_ctr        <= '0;
         irq_en       <= 2'b00;
         irq_stat     <= 2'b00;
         rep_cnt      <= '0;
         rep_left     <= '0;
         cycles       <= '0;
      end else begin
         capture_sums <= 1'b0;
         clear_acc    <= 1'b0;
         irq          <= |(irq_stat & irq_en);

         if (wr_irq_en)
            irq_en <= mmio_wdata[1:0];
         if (wr_rep)
            for (int b = 0; b < REP_W; b++)
               if (mmio_wstrb[b/8])
                  rep_cnt[b] <= mmio_wdata[b];

         // Clears are issued first so that a same-cycle event assignment below overrides them.
         if (wr_irq_stat)
            irq_stat <= irq_stat & ~mmio_wdata[1:0];
         if (clr_done) begin
            done <= 1'b0;
            err  <= 1'b0;
         end
         if (ab_busy_err) begin
            err         <= 1'b1;
            irq_stat[1] <= 1'b1;
         end

         if (abort) begin
            st    <= S_IDLE;
            busy  <= 1'b0;
            t_ctr <= '0;
         end else begin
            case (st)
               S_IDLE, S_DONE: begin
                  if (start) begin
                     st        <= S_RUN;
                     busy      <= 1'b1;
                     done      <= 1'b0;
                     t_ctr     <= '0;
                     rep_left  <= rep_cnt;
                     cycles    <= '0;
                     clear_acc <= 1'b1;
                  end
               end
               S_RUN: begin
                  if (start) begin
                     err         <= 1'b1;
                     irq_stat[1] <= 1'b1;
                  end
                  if (cycles != 32'hFFFF_FFFF)
                     cycles <= cycles + 32'd1;
                  if (t_ctr == T_LAST) begin
                     capture_sums <= 1'b1;
                     t_ctr        <= '0;
                     if (rep_left != '0) begin
                        rep_left  <= rep_left - 1'b1;
                        clear_acc <= 1'b1;
                     end else begin
                        st          <= S_DONE;
                        busy        <= 1'b0;
                        done        <= 1'b1;
                        irq_stat[0] <= 1'b1;
                     end
                  end else begin
                     t_ctr <= t_ctr + 1'b1;
                  end
               end
               default: begin
                  st   <= S_IDLE;
                  busy <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_tpu_mmio_ctrl.sv
// Directed bench for tpu_mmio_ctrl at N=4, DATA_W=8: register map, packed writes, runs, repeats, errors, abort and reset.
module tb_tpu_mmio_ctrl;
   logic         clk = 1'b0;
   logic         rst;
   logic         mmio_wr, mmio_rd;
   logic [15:0]  mmio_addr;
   logic [31:0]  mmio_wdata;
   logic [3:0]   mmio_wstrb;
   logic [127:0] a_flat, b_flat;
   logic [511:0] c_flat;
   logic [31:0]  mmio_rdata;
   logic         mmio_ready, busy, done, irq, capture_sums, clear_acc;
   logic [3:0]   t_ctr;
   logic [1:0]   state;
   logic [3:0]   we_a, we_b;
   logic [1:0]   addr_a, addr_b;
   logic [31:0]  wdata_a, wdata_b;

   int total = 0;
   int bad   = 0;
   int cap_cnt = 0, clr_cnt = 0, busy_cnt = 0;

   tpu_mmio_ctrl dut (
      .clk(clk), .rst(rst), .mmio_wr(mmio_wr), .mmio_rd(mmio_rd), .mmio_addr(mmio_addr),
      .mmio_wdata(mmio_wdata), .mmio_wstrb(mmio_wstrb), .a_flat(a_flat), .b_flat(b_flat),
      .c_flat(c_flat), .mmio_rdata(mmio_rdata), .mmio_ready(mmio_ready), .busy(busy),
      .done(done), .irq(irq), .capture_sums(capture_sums), .clear_acc(clear_acc),
      .t_ctr(t_ctr), .state(state), .we_a(we_a), .we_b(we_b), .addr_a(addr_a),
      .addr_b(addr_b), .wdata_a(wdata_a), .wdata_b(wdata_b)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (capture_sums) cap_cnt++;
      if (clear_acc) clr_cnt++;
      if (busy) busy_cnt++;
   end

   task automatic mmio_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s);
      @(negedge clk);
      mmio_wr = 1'b1; mmio_addr = a; mmio_wdata = d; mmio_wstrb = s;
      @(posedge clk); #1;
      mmio_wr = 1'b0; mmio_wstrb = 4'h0;
   endtask

   task automatic mmio_read(input logic [15:0] a, output logic [31:0] d);
      @(negedge clk);
      mmio_rd = 1'b1; mmio_addr = a;
      #1 d = mmio_rdata;
      mmio_rd = 1'b0;
   endtask

   task automatic wait_tctr(input logic [3:0] k);
      bit ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (t_ctr == k) begin ok = 1'b1; break; end
      end
      total++;
      if (!ok) begin bad++; $display("FAIL wait_tctr timeout got=%0d want=%0d", t_ctr, k); end
   endtask

   task automatic wait_idle(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1;
         if (!busy) begin ok = 1'b1; break; end
      end
      total++;
      if (!ok) begin bad++; $display("FAIL wait_idle timeout busy=%0b want=0", busy); end
   endtask

   task automatic test_reset();
      logic [31:0] d;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++; if (state !== 2'd0) begin bad++; $display("FAIL rst_state got=%0h want=0", state); end
      total++; if ({busy, done, irq, capture_sums, clear_acc} !== 5'b0) begin bad++; $display("FAIL rst_flags got=%0b want=0", {busy, done, irq, capture_sums, clear_acc}); end
      total++; if (t_ctr !== 4'd0) begin bad++; $display("FAIL rst_tctr got=%0h want=0", t_ctr); end
      total++; if ({we_a, we_b, mmio_rdata} !== 40'h0) begin bad++; $display("FAIL rst_comb got=%0h want=0", {we_a, we_b, mmio_rdata}); end
      total++; if (mmio_ready !== 1'b1) begin bad++; $display("FAIL ready got=%0b want=1", mmio_ready); end
      @(negedge clk); rst = 1'b0;
      mmio_read(16'h0000, d);
      total++; if (d !== 32'h5450_0002) begin bad++; $display("FAIL id got=%0h want=54500002", d); end
      mmio_read(16'h0004, d);
      total++; if (d !== 32'h0002_0000) begin bad++; $display("FAIL version got=%0h want=20000", d); end
      mmio_read(16'h000C, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_status got=%0h want=0", d); end
      mmio_read(16'h0018, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_repeat got=%0h want=0", d); end
      mmio_read(16'h001C, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_cycles got=%0h want=0", d); end
   endtask

   task automatic test_packed_write();
      logic [31:0] d;
      @(negedge clk);
      mmio_wr = 1'b1; mmio_addr = 16'h0100; mmio_wdata = 32'h4433_2211; mmio_wstrb = 4'b0101;
      #1;
      total++; if (we_a !== 4'b0101) begin bad++; $display("FAIL pk_we_a got=%0b want=0101", we_a); end
      total++; if (addr_a !== 2'd0) begin bad++; $display("FAIL pk_addr_a got=%0h want=0", addr_a); end
      total++; if ({wdata_a[23:16], wdata_a[7:0]} !== 16'h3311) begin bad++; $display("FAIL pk_lanes got=%0h want=3311", {wdata_a[23:16], wdata_a[7:0]}); end
      total++; if (we_b !== 4'b0000) begin bad++; $display("FAIL pk_we_b_idle got=%0b want=0", we_b); end
      mmio_addr = 16'h010C; mmio_wstrb = 4'b1111;
      #1;
      total++; if ({we_a, addr_a} !== 6'b1111_11) begin bad++; $display("FAIL pk_w3 got=%0b want=111111", {we_a, addr_a}); end
      mmio_addr = 16'h0204; mmio_wstrb = 4'b0011;
      #1;
      total++; if ({we_b, addr_b, we_a} !== 10'b0011_01_0000) begin bad++; $display("FAIL pk_b got=%0b want=0011010000", {we_b, addr_b, we_a}); end
      mmio_addr = 16'h0110; mmio_wstrb = 4'b1111;
      #1;
      total++; if ({we_a, we_b} !== 8'h0) begin bad++; $display("FAIL pk_oob got=%0h want=0", {we_a, we_b}); end
      @(posedge clk); #1;
      mmio_wr = 1'b0; mmio_wstrb = 4'h0;
      mmio_read(16'h0104, d);
      total++; if (d !== 32'h1716_1514) begin bad++; $display("FAIL rd_a got=%0h want=17161514", d); end
      mmio_read(16'h020C, d);
      total++; if (d !== 32'hAFAE_ADAC) begin bad++; $display("FAIL rd_b got=%0h want=afaeadac", d); end
      mmio_read(16'h0314, d);
      total++; if (d !== 32'h1000_0005) begin bad++; $display("FAIL rd_c got=%0h want=10000005", d); end
      mmio_read(16'h0340, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL rd_c_oob got=%0h want=0", d); end
      mmio_read(16'h0020, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL rd_unmapped got=%0h want=0", d); end
   endtask

   task automatic test_single_run();
      logic [31:0] d;
      bit ok;
      int c0 = cap_cnt, k0 = clr_cnt, b0 = busy_cnt;
      mmio_write(16'h0008, 32'h1, 4'hF);
      total++; if ({busy, clear_acc, t_ctr, state} !== 8'b1_1_0000_01) begin bad++; $display("FAIL run_entry got=%0b want=11000001", {busy, clear_acc, t_ctr, state}); end
      wait_idle(ok);
      total++; if ({capture_sums, done, state} !== 4'b1_1_10) begin bad++; $display("FAIL run_end got=%0b want=1110", {capture_sums, done, state}); end
      repeat (2) @(posedge clk); #1;
      total++; if (busy_cnt - b0 !== 12) begin bad++; $display("FAIL run_busy got=%0d want=12", busy_cnt - b0); end
      total++; if ({cap_cnt - c0, clr_cnt - k0} !== {32'd1, 32'd1}) begin bad++; $display("FAIL run_pulses cap=%0d clr=%0d want=1,1", cap_cnt - c0, clr_cnt - k0); end
      mmio_read(16'h000C, d);
      total++; if (d !== 32'h2) begin bad++; $display("FAIL run_status got=%0h want=2", d); end
      mmio_read(16'h001C, d);
      total++; if (d !== 32'd12) begin bad++; $display("FAIL run_cycles got=%0d want=12", d); end
   endtask

   task automatic test_repeat_irq();
      logic [31:0] d;
      bit ok;
      int c0, k0, b0;
      mmio_write(16'h0018, 32'h2, 4'hF);
      mmio_write(16'h0010, 32'h1, 4'hF);
      mmio_read(16'h0018, d);
      total++; if (d !== 32'h2) begin bad++; $display("FAIL rep_readback got=%0h want=2", d); end
      c0 = cap_cnt; k0 = clr_cnt; b0 = busy_cnt;
      mmio_write(16'h0008, 32'h1, 4'hF);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL rep_done_clr got=%0b want=0", done); end
      wait_idle(ok);
      repeat (2) @(posedge clk); #1;
      total++; if (busy_cnt - b0 !== 36) begin bad++; $display("FAIL rep_busy got=%0d want=36", busy_cnt - b0); end
      total++; if (cap_cnt - c0 !== 3) begin bad++; $display("FAIL rep_cap got=%0d want=3", cap_cnt - c0); end
      total++; if (clr_cnt - k0 !== 3) begin bad++; $display("FAIL rep_clr got=%0d want=3", clr_cnt - k0); end
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL rep_irq got=%0b want=1", irq); end
      mmio_read(16'h001C, d);
      total++; if (d !== 32'd36) begin bad++; $display("FAIL rep_cycles got=%0d want=36", d); end
      mmio_write(16'h0014, 32'h1, 4'hF);
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL w1c_irq_lag got=%0b want=1", irq); end
      @(posedge clk); #1;
      total++; if (irq !== 1'b0) begin bad++; $display("FAIL w1c_irq got=%0b want=0", irq); end
      mmio_read(16'h0014, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL w1c_stat got=%0h want=0", d); end
      mmio_write(16'h0008, 32'h2, 4'hF);
      mmio_read(16'h000C, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL clear_done got=%0h want=0", d); end
   endtask

   task automatic test_error();
      logic [31:0] d;
      bit ok;
      int b0;
      mmio_write(16'h0018, 32'h0, 4'hF);
      mmio_write(16'h0010, 32'h2, 4'hF);
      b0 = busy_cnt;
      mmio_write(16'h0008, 32'h3, 4'hF);
      total++; if ({busy, done} !== 2'b10) begin bad++; $display("FAIL err_start_clr got=%0b want=10", {busy, done}); end
      wait_tctr(4'd5);
      mmio_write(16'h0008, 32'h1, 4'hF);
      total++; if ({t_ctr, clear_acc} !== 5'b0110_0) begin bad++; $display("FAIL err_no_restart got=%0b want=01100", {t_ctr, clear_acc}); end
      @(negedge clk);
      mmio_wr = 1'b1; mmio_addr = 16'h0100; mmio_wdata = 32'hDEAD_BEEF; mmio_wstrb = 4'hF;
      #1;
      total++; if (we_a !== 4'b0) begin bad++; $display("FAIL err_we_a got=%0b want=0", we_a); end
      @(posedge clk); #1;
      mmio_wr = 1'b0; mmio_wstrb = 4'h0;
      mmio_read(16'h000C, d);
      total++; if (d !== 32'h5) begin bad++; $display("FAIL err_status got=%0h want=5", d); end
      total++; if (irq !== 1'b1) begin bad++; $display("FAIL err_irq got=%0b want=1", irq); end
      wait_idle(ok);
      repeat (2) @(posedge clk); #1;
      total++; if (busy_cnt - b0 !== 12) begin bad++; $display("FAIL err_busy got=%0d want=12", busy_cnt - b0); end
      mmio_read(16'h0014, d);
      total++; if (d !== 32'h3) begin bad++; $display("FAIL err_irqstat got=%0h want=3", d); end
      mmio_read(16'h000C, d);
      total++; if (d !== 32'h6) begin bad++; $display("FAIL err_sticky got=%0h want=6", d); end
      mmio_write(16'h0014, 32'h3, 4'hF);
      mmio_write(16'h0008, 32'h2, 4'hF);
      mmio_read(16'h000C, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL err_cleared got=%0h want=0", d); end
   endtask

   task automatic test_abort();
      logic [31:0] d;
      int c0 = cap_cnt;
      mmio_write(16'h0008, 32'h1, 4'hF);
      wait_tctr(4'd7);
      mmio_write(16'h0008, 32'h4, 4'hF);
      total++; if ({state, busy, t_ctr} !== 7'b00_0_0000) begin bad++; $display("FAIL abort_state got=%0b want=0", {state, busy, t_ctr}); end
      repeat (15) @(posedge clk); #1;
      total++; if (cap_cnt - c0 !== 0) begin bad++; $display("FAIL abort_cap got=%0d want=0", cap_cnt - c0); end
      mmio_read(16'h000C, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL abort_status got=%0h want=0", d); end
      mmio_write(16'h0008, 32'h5, 4'hF);
      total++; if ({state, busy} !== 3'b000) begin bad++; $display("FAIL start_abort got=%0b want=000", {state, busy}); end
   endtask

   task automatic test_reset_midrun();
      logic [31:0] d;
      int c0;
      mmio_write(16'h0018, 32'h2, 4'hF);
      mmio_write(16'h0010, 32'h3, 4'hF);
      mmio_write(16'h0008, 32'h1, 4'hF);
      wait_tctr(4'd3);
      c0 = cap_cnt;
      @(negedge clk); rst = 1'b1;
      @(posedge clk); #1;
      total++; if ({state, busy, done, irq, capture_sums, clear_acc, t_ctr} !== 11'b0) begin bad++; $display("FAIL rst_mid got=%0b want=0", {state, busy, done, irq, capture_sums, clear_acc, t_ctr}); end
      @(negedge clk); rst = 1'b0;
      repeat (15) @(posedge clk); #1;
      total++; if (cap_cnt - c0 !== 0) begin bad++; $display("FAIL rst_mid_cap got=%0d want=0", cap_cnt - c0); end
      mmio_read(16'h0018, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_mid_repeat got=%0h want=0", d); end
      mmio_read(16'h0010, d);
      total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_mid_irqen got=%0h want=0", d); end
   endtask

   initial begin
      mmio_wr = 1'b0; mmio_rd = 1'b0; mmio_addr = 16'h0; mmio_wdata = 32'h0; mmio_wstrb = 4'h0;
      for (int i = 0; i < 16; i++) begin
         a_flat[i*8 +: 8]   = 8'(8'h10 + i);
         b_flat[i*8 +: 8]   = 8'(8'hA0 + i);
         c_flat[i*32 +: 32] = 32'h1000_0000 + 32'(i);
      end
      test_reset();
      test_packed_write();
      test_single_run();
      test_repeat_irq();
      test_error();
      test_abort();
      test_reset_midrun();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
